// File: rtl/adc_meas.sv
// ----------------------------------------------------------------------------
// adc_meas -- windowed ADC measurement block.
//
// Generates the ADC sample clock (sys_clk/2), registers one sample per
// adc_clk period and, on request, measures a window of WIN_LEN samples. It
// reports the window maximum, minimum and peak-to-peak value and, when
// enabled, the number of rising threshold crossings.
//
// Optional feature macro: ADC_MEAS_CROSS_EN
//   defined   : crossing detector active. The threshold is the midpoint of the
//               previous window. Arming and counting use +/-HYST hysteresis.
//   undefined : no detector or threshold logic; cross_cnt is tied to 0.
//
// Handshake: start is a single-cycle request that is accepted only while
// idle (busy low). Requests while busy are dropped. meas_valid is a
// one-cycle strobe with no back-pressure. The result outputs hold until the
// next strobe.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   window request
//   adc_data   in   8-bit unsigned ADC sample
//   adc_clk    out  ADC sample clock, sys_clk/2
//   busy       out  window open (capture or done)
//   meas_valid out  one-cycle pulse, results updated
//   vmax/vmin  out  window maximum / minimum
//   vpp        out  vmax - vmin
//   cross_cnt  out  rising threshold crossings (saturating)
//   dbg_state  out  FSM state for observation
// ----------------------------------------------------------------------------
module adc_meas #(
    parameter int WIN_LEN = 4096,
    parameter int HYST    = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [7:0]  adc_data,
    output logic        adc_clk,
    output logic        busy,
    output logic        meas_valid,
    output logic [7:0]  vmax,
    output logic [7:0]  vmin,
    output logic [7:0]  vpp,
    output logic [15:0] cross_cnt,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAPT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int             CW       = $clog2(WIN_LEN);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIN_LEN - 1);

    if (WIN_LEN < 16 || WIN_LEN > 65536 || (WIN_LEN & (WIN_LEN - 1)) != 0 ||
        HYST < 0 || HYST > 63) begin : g_bad_param
        $error("adc_meas: WIN_LEN must be a power of two in 16..65536, HYST in 0..63");
    end

    logic [1:0]    state;
    logic [7:0]    smp_q;
    logic          smp_vld;
    logic          take;
    logic [CW-1:0] smp_cnt;
    logic          win_full;
    logic [7:0]    run_max;
    logic [7:0]    run_min;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // adc_clk is high in the cycle before it falls; that cycle is the sample
    // strobe, so adc_data is taken on the falling edge of adc_clk.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            adc_clk <= 1'b0;
        end else begin
            adc_clk <= ~adc_clk;
        end
    end

    // A sample is flagged for the datapath only when it was registered while
    // capturing. This way a sample taken on the same edge that accepts start
    // never leaks into the window.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            smp_q   <= 8'h00;
            smp_vld <= 1'b0;
        end else begin
            if (adc_clk) begin
                smp_q <= adc_data;
            end
            smp_vld <= adc_clk && (state == ST_CAPT) && !win_full;
        end
    end

    assign take = smp_vld && (state == ST_CAPT) && !win_full;

    // The last sample sets win_full. CAPT moves to DONE on the following
    // edge, and DONE publishes the results one cycle later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            smp_cnt    <= '0;
            win_full   <= 1'b0;
            run_max    <= 8'h00;
            run_min    <= 8'hFF;
            meas_valid <= 1'b0;
            vmax       <= 8'h00;
            vmin       <= 8'h00;
            vpp        <= 8'h00;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CAPT;
                        smp_cnt  <= '0;
                        win_full <= 1'b0;
                        run_max  <= 8'h00;
                        run_min  <= 8'hFF;
                    end
                end
                ST_CAPT: begin
                    if (win_full) begin
                        state <= ST_DONE;
                    end else if (take) begin
                        if (smp_q > run_max) run_max <= smp_q;
                        if (smp_q < run_min) run_min <= smp_q;
                        if (smp_cnt == LAST_IDX) win_full <= 1'b1;
                        smp_cnt <= smp_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    // At least one sample was seen, so run_max >= run_min.
                    vmax       <= run_max;
                    vmin       <= run_min;
                    vpp        <= run_max - run_min;
                    meas_valid <= 1'b1;
                    win_full   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADC_MEAS_CROSS_EN
    logic [7:0] thr;
    logic [7:0] thr_lo;
    logic [7:0] thr_hi;
    logic [9:0] lo_ext;
    logic [9:0] hi_ext;
    logic [8:0] mid_sum;
    logic       armed;
    logic [15:0] xcnt;

    // Hysteresis bounds are computed in 10 bits so that underflow and
    // overflow can be clamped to the 8-bit sample range.
    always_comb begin
        lo_ext  = {2'b00, thr} - 10'(HYST);
        hi_ext  = {2'b00, thr} + 10'(HYST);
        thr_lo  = lo_ext[9] ? 8'h00 : lo_ext[7:0];
        thr_hi  = (hi_ext > 10'd255) ? 8'hFF : hi_ext[7:0];
        mid_sum = {1'b0, run_max} + {1'b0, run_min};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            thr       <= 8'd128;
            armed     <= 1'b0;
            xcnt      <= 16'h0000;
            cross_cnt <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        armed <= 1'b0;
                        xcnt  <= 16'h0000;
                    end
                end
                ST_CAPT: begin
                    if (take) begin
                        if (armed && (smp_q > thr_hi)) begin
                            armed <= 1'b0;
                            if (xcnt != 16'hFFFF) xcnt <= xcnt + 16'd1;
                        end else if (smp_q < thr_lo) begin
                            armed <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    cross_cnt <= xcnt;
                    thr       <= mid_sum[8:1];
                end
                default: begin
                    armed <= 1'b0;
                end
            endcase
        end
    end
`else
    assign cross_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_adc_meas.sv
// ----------------------------------------------------------------------------
// tb_adc_meas -- directed/randomized bench for adc_meas.
// An ADC model drives one new value per adc_clk period and records every value
// present at an adc_clk falling edge. Each window's expected results come from
// the recorded samples taken after start is accepted.
// ----------------------------------------------------------------------------
module tb_adc_meas;

  localparam int W  = 64;
  localparam int HY = 8;

  // clock / reset
  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic [7:0]  adc_data  = 8'h00;
  logic        adc_clk;
  logic        busy;
  logic        meas_valid;
  logic [7:0]  vmax;
  logic [7:0]  vmin;
  logic [7:0]  vpp;
  logic [15:0] cross_cnt;
  logic [1:0]  dbg_state;

  always #10 sys_clk = ~sys_clk;

  adc_meas #(.WIN_LEN(W), .HYST(HY)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .adc_data   (adc_data),
    .adc_clk    (adc_clk),
    .busy       (busy),
    .meas_valid (meas_valid),
    .vmax       (vmax),
    .vmin       (vmin),
    .vpp        (vpp),
    .cross_cnt  (cross_cnt),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ADC stimulus model
  int         mode    = 0;   // 0 const, 1 random, 2 ramp, 3 square
  int         gen_idx = 0;
  logic [7:0] c_val   = 8'h00;
  logic [7:0] sq_lo   = 8'h00;
  logic [7:0] sq_hi   = 8'h00;
  int         rnd_lo  = 0;
  int         rnd_hi  = 255;
  logic [7:0] adc_hist[$];
  int         valid_cnt = 0;

  // reference model state and expectations
  int          thr_m = 128;
  logic [7:0]  e_max;
  logic [7:0]  e_min;
  logic [7:0]  e_pp;
  logic [15:0] e_cc;

  always @(posedge adc_clk) begin
    #1;
    case (mode)
      0:       adc_data = c_val;
      1:       adc_data = 8'($urandom_range(rnd_hi, rnd_lo));
      2:       adc_data = 8'((gen_idx * 4) % 256);
      default: adc_data = (((gen_idx / 8) % 2) == 0) ? sq_lo : sq_hi;
    endcase
    gen_idx++;
  end

  always @(negedge adc_clk) adc_hist.push_back(adc_data);

  always @(posedge sys_clk) if (meas_valid) valid_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window statistics straight from the sample list: max, min, difference,
  // and rising crossings of the previous window's midpoint with hysteresis.
  function automatic void model(input int idx);
    int mx = 0;
    int mn = 255;
    int cc = 0;
    bit armed = 1'b0;
    int lo;
    int hi;
    int s;
    lo = thr_m - HY;
    if (lo < 0) lo = 0;
    hi = thr_m + HY;
    if (hi > 255) hi = 255;
    for (int i = 0; i < W; i++) begin
      s = int'(adc_hist[idx + i]);
      if (s > mx) mx = s;
      if (s < mn) mn = s;
      if (armed && s > hi) begin
        if (cc < 65535) cc++;
        armed = 1'b0;
      end else if (s < lo) begin
        armed = 1'b1;
      end
    end
    e_max = 8'(mx);
    e_min = 8'(mn);
    e_pp  = 8'(mx - mn);
    e_cc  = 16'(cc);
`ifndef ADC_MEAS_CROSS_EN
    e_cc  = 16'h0000;
`endif
    thr_m = (mx + mn) / 2;
  endfunction

  task automatic check_results(input string tag);
    chk({tag, "_vmax"}, vmax, e_max);
    chk({tag, "_vmin"}, vmin, e_min);
    chk({tag, "_vpp"}, vpp, e_pp);
    chk({tag, "_cross"}, cross_cnt, e_cc);
  endtask

  // One window: start pulse, bounded wait for meas_valid, model comparison.
  // poke issues a second start while busy, which must be ignored.
  task automatic run_window(input string tag, input bit poke);
    int idx;
    int n;
    int v0;
    bit seen;
    v0 = valid_cnt;
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    idx   = adc_hist.size();
    start = 1'b0;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 2 * W + 10) begin
      @(posedge sys_clk);
      #1;
      n++;
      start = (poke && n == 20);
      if (n == 30) chk({tag, "_busy"}, busy, 1'b1);
      if (meas_valid) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_seen"}, seen, 1'b1);
    if (seen) begin
      chk({tag, "_latency"}, (n + 1 <= 2 * W + 4), 1'b1);
      model(idx);
      check_results(tag);
      @(posedge sys_clk);
      #1;
      chk({tag, "_pulse_len"}, meas_valid, 1'b0);
      chk({tag, "_n_valid"}, valid_cnt - v0, 1);
    end
  endtask

  task automatic hold_check(input string tag);
    repeat (10) @(posedge sys_clk);
    #1;
    check_results({tag, "_hold"});
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_valid"}, meas_valid, 1'b0);
  endtask

  // start held high: consecutive windows, each spacing checked.
  task automatic back_to_back();
    int idx;
    int n;
    int v0;
    bit seen;
    v0 = valid_cnt;
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    idx = adc_hist.size();
    for (int k = 0; k < 3; k++) begin
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 2 * W + 10) begin
        @(posedge sys_clk);
        #1;
        n++;
        if (k > 0 && n == 1) idx = adc_hist.size();
        if (meas_valid) seen = 1'b1;
      end
      if (k == 2) start = 1'b0;
      chk($sformatf("b2b%0d_seen", k), seen, 1'b1);
      if (seen) begin
        if (k > 0) chk($sformatf("b2b%0d_spacing", k), (n >= 2 * W + 3 && n <= 2 * W + 4), 1'b1);
        model(idx);
        check_results($sformatf("b2b%0d", k));
      end
    end
    start = 1'b0;
    repeat (2 * W + 10) @(posedge sys_clk);
    #1;
    chk("b2b_total_valid", valid_cnt - v0, 3);
    chk("b2b_idle", busy, 1'b0);
  endtask

  task automatic reset_mid_window();
    int v0;
    @(negedge sys_clk);
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;
    chk("rst_pre_busy", busy, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_vmax", vmax, 8'h00);
    chk("rst_vmin", vmin, 8'h00);
    chk("rst_vpp", vpp, 8'h00);
    chk("rst_cross", cross_cnt, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", meas_valid, 1'b0);
    chk("rst_adc_clk", adc_clk, 1'b0);
    thr_m = 128;
    v0 = valid_cnt;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2 * W + 10) @(posedge sys_clk);
    #1;
    chk("rst_no_valid", valid_cnt - v0, 0);
    chk("rst_stays_idle", busy, 1'b0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_vmax", vmax, 8'h00);
    chk("reset_vmin", vmin, 8'h00);
    chk("reset_vpp", vpp, 8'h00);
    chk("reset_cross", cross_cnt, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", meas_valid, 1'b0);
    chk("reset_adc_clk", adc_clk, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);

    // constant input
    mode = 0;
    c_val = 8'h5A;
    repeat (4) @(posedge sys_clk);
    run_window("const", 1'b0);
    chk("const_vmax_5a", vmax, 8'h5A);
    chk("const_vpp_0", vpp, 8'h00);
    chk("const_cross_0", cross_cnt, 16'h0000);
    hold_check("const");

    // ramp, step 4: one full sweep per window
    mode = 2;
    gen_idx = 0;
    run_window("ramp1", 1'b0);
    run_window("ramp2", 1'b0);
    chk("ramp_vpp_fc", vpp, 8'hFC);

    // random data, one window with an ignored start while busy
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      rnd_lo = $urandom_range(0, 100);
      rnd_hi = $urandom_range(150, 255);
      run_window($sformatf("rand%0d", i), (i == 1));
    end
    hold_check("rand");

    // square 0x20/0xE0, 16-sample period
    mode = 3;
    sq_lo = 8'h20;
    sq_hi = 8'hE0;
    gen_idx = 0;
    run_window("sq_wide", 1'b0);
    chk("sq_wide_vpp_c0", vpp, 8'hC0);

    // square inside the hysteresis band around 128
    sq_lo = 8'h7C;
    sq_hi = 8'h84;
    run_window("sq_narrow", 1'b0);
    chk("sq_narrow_vpp_8", vpp, 8'h08);
    chk("sq_narrow_cross_0", cross_cnt, 16'h0000);

    // reset in the middle of a window, then a normal window
    mode = 1;
    rnd_lo = 0;
    rnd_hi = 255;
    reset_mid_window();
    run_window("after_rst", 1'b0);

    // back-to-back windows with start held high
    back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_meas.md
ADC_MEAS -- requirements
Module: adc_meas

Interface
REQ-001 SHALL have parameter WIN_LEN, default 4096, samples per measurement window (power of two, 16..65536).
REQ-002 SHALL have parameter HYST, default 8, crossing hysteresis in LSB (0..63).
REQ-003 SHALL have port sys_clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle window request.
REQ-006 SHALL have port adc_data  input  8  unsigned ADC sample.
REQ-007 SHALL have port adc_clk  output  1  ADC sample clock, sys_clk/2.
REQ-008 SHALL have port busy  output  1  high while a window is open.
REQ-009 SHALL have port meas_valid  output  1  one-cycle pulse, results updated.
REQ-010 SHALL have ports vmax, vmin, vpp  output  8 each  window maximum, minimum, max-min.
REQ-011 SHALL have port cross_cnt  output  16  rising threshold crossings in window.

Function
REQ-012 adc_clk SHALL be a register toggling every sys_clk; sample strobe smp_en SHALL be the cycle in which adc_clk is registered high-to-low.
REQ-013 adc_data SHALL be registered on every smp_en; only registered samples enter the datapath.
REQ-014 FSM SHALL have states IDLE, CAPT, DONE; reset state IDLE.
REQ-015 IDLE -> CAPT on start; running max SHALL load 0x00, running min 0xFF, sample counter 0, crossing counter 0.
REQ-016 CAPT SHALL process exactly WIN_LEN samples, one per smp_en, then go to DONE in the cycle after the last sample's update.
REQ-017 DONE SHALL last one cycle: latch vmax, vmin, vpp = vmax-vmin (never negative), cross_cnt, pulse meas_valid, return to IDLE.
REQ-018 busy SHALL be high in CAPT and DONE; start while busy SHALL be ignored.
REQ-019 Threshold thr SHALL equal (vmax+vmin)>>1 of the last completed window, 9-bit sum, 128 after reset.
REQ-020 Crossing detector SHALL arm when sample < thr-HYST and count one crossing when armed and sample > thr+HYST, then disarm; bounds clamp at 0 and 255.
REQ-021 Detector SHALL start disarmed each window.
REQ-022 cross_cnt SHALL saturate at 0xFFFF.
REQ-023 Outputs SHALL hold their values between meas_valid pulses.
REQ-024 Latency start -> meas_valid SHALL be at most 2*WIN_LEN+4 sys_clk cycles.
REQ-025 Constant input SHALL yield vpp=0 and cross_cnt=0.

Reset
REQ-026 Assertion of sys_rst_n low SHALL immediately force: state IDLE, adc_clk 0, busy 0, meas_valid 0, vmax 0, vmin 0, vpp 0, cross_cnt 0, thr 128.
REQ-027 Reset mid-window SHALL abandon the window with no meas_valid; a new start SHALL be required after release.

Configuration
REQ-028 Macro ADC_MEAS_CROSS_EN defined: crossing detector and cross_cnt function per REQ-019..022.
REQ-029 Macro ADC_MEAS_CROSS_EN undefined: detector and threshold logic SHALL be absent, cross_cnt SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-030 Constant adc_data=0x5A, WIN_LEN=16, start -> meas_valid once, vmax=vmin=0x5A, vpp=0, cross_cnt=0.
REQ-031 Ramp 0x00..0xFF repeating, WIN_LEN=4096, second window -> vmax=0xFF, vmin=0x00, vpp=0xFF, cross_cnt=16.
REQ-032 Square 0x20/0xE0, 64-sample period, WIN_LEN=1024, HYST=8 -> vpp=0xC0, cross_cnt=16 (15 if window starts high).
REQ-033 Square 0x7C/0x84 (inside hysteresis around 128), HYST=8 -> cross_cnt=0, vpp=0x08.
REQ-034 Reset pulse at sample 100 of a window -> all outputs 0 immediately, no meas_valid, next start completes normally.
REQ-035 start held high continuously -> back-to-back windows, one meas_valid each, spacing 2*WIN_LEN+3..+4 cycles.
